// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants, wiring tables, FSM state encoding and
// mod-26 helpers for the sequential Enigma engine.
// Wiring index 0..4 selects historical rotor I..V.
package enigma_pkg;

  localparam int ALPHA = 26;
  localparam int CW    = 5;

  // Wiring strings, letter j of the alphabet maps to character j of the string.
  localparam logic [8*ALPHA-1:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*ALPHA-1:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [8*ALPHA-1:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [8*ALPHA-1:0] WIRE_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [8*ALPHA-1:0] WIRE_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";
  localparam logic [8*ALPHA-1:0] REFL_B   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STEP = 3'd1,
    S_FWD  = 3'd2,
    S_REFL = 3'd3,
    S_BWD  = 3'd4,
    S_OUT  = 3'd5
  } state_e;

  function automatic logic [CW-1:0] add26(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
    return s[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] sub26(input logic [CW-1:0] a, input logic [CW-1:0] b);
    if (a >= b) return a - b;
    else        return a + 5'(ALPHA) - b;
  endfunction

  // Pick character idx out of a 26-letter ASCII table and return it as 0..25.
  function automatic logic [CW-1:0] tbl_at(input logic [8*ALPHA-1:0] s, input logic [CW-1:0] idx);
    logic [7:0] ch;
    if (idx >= 5'(ALPHA)) return idx;
    ch = s[8*(ALPHA-1-int'(idx)) +: 8];
    return CW'(ch - 8'd65);
  endfunction

  function automatic logic [CW-1:0] wiring_fwd(input logic [2:0] w, input logic [CW-1:0] c);
    case (w)
      3'd0:    return tbl_at(WIRE_I, c);
      3'd1:    return tbl_at(WIRE_II, c);
      3'd2:    return tbl_at(WIRE_III, c);
      3'd3:    return tbl_at(WIRE_IV, c);
      3'd4:    return tbl_at(WIRE_V, c);
      default: return c;
    endcase
  endfunction

  // Inverse wiring: the j whose forward image is c (constant table, reduces to a ROM).
  function automatic logic [CW-1:0] wiring_inv(input logic [2:0] w, input logic [CW-1:0] c);
    logic [CW-1:0] r;
    r = c;
    for (int j = 0; j < ALPHA; j++) begin
      if (wiring_fwd(w, 5'(j)) == c) r = 5'(j);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] notch_of(input logic [2:0] w);
    case (w)
      3'd0:    return 5'd16;
      3'd1:    return 5'd4;
      3'd2:    return 5'd21;
      3'd3:    return 5'd9;
      3'd4:    return 5'd25;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [CW-1:0] reflect(input logic [CW-1:0] c);
    return tbl_at(REFL_B, c);
  endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// enigma_rotor_map: one rotor substitution, c -> (T[(c+p) mod 26] - p) mod 26.
// Ports: char_i (0..25), pos_i rotor position, rotor_i rotor index (0 = rightmost),
//        dir_i (0 forward wiring, 1 inverse wiring), char_o result.
// Rotor i carries historical wiring NUM_ROTORS-i, i.e. wiring index NUM_ROTORS-1-i.
module enigma_rotor_map
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3
) (
  input  logic [CW-1:0] char_i,
  input  logic [CW-1:0] pos_i,
  input  logic [2:0]    rotor_i,
  input  logic          dir_i,
  output logic [CW-1:0] char_o
);

  logic [2:0]    wiring_s;
  logic [CW-1:0] entry_s;
  logic [CW-1:0] mapped_s;

  always_comb begin
    wiring_s = 3'(NUM_ROTORS - 1) - rotor_i;
    entry_s  = add26(char_i, pos_i);
    if (dir_i) mapped_s = wiring_inv(wiring_s, entry_s);
    else       mapped_s = wiring_fwd(wiring_s, entry_s);
    char_o = sub26(mapped_s, pos_i);
  end

endmodule

// File: rtl/enigma_core.sv
// enigma_core: sequential Enigma engine, one substitution stage per clock,
// with a single time-shared rotor-map datapath.
// Ports: clk, rst (sync, active-high); cfg_load/cfg_pos load rotor positions in IDLE;
//        in_valid/in_ready/in_char input handshake; out_valid/out_ready/out_char
//        output handshake; pos current positions; busy = FSM not idle.
// Optional macro ENIGMA_PLUGBOARD_EN adds plug_we/plug_a/plug_b for a
// programmable plugboard; without it the plugboard is identity.
module enigma_core
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  logic [NUM_ROTORS*CW-1:0]   cfg_pos,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CW-1:0]              in_char,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW-1:0]              out_char,
  output logic [NUM_ROTORS*CW-1:0]   pos,
  output logic                       busy
`ifdef ENIGMA_PLUGBOARD_EN
  ,
  input  logic                       plug_we,
  input  logic [CW-1:0]              plug_a,
  input  logic [CW-1:0]              plug_b
`endif
);

  localparam logic [2:0] LAST = 3'(NUM_ROTORS - 1);

  state_e        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] pos_q [NUM_ROTORS];
  logic [CW-1:0] pos_d [NUM_ROTORS];
  logic [CW-1:0] out_char_q;
  logic          in_ready_q, out_valid_q, busy_q;
  logic          accept_s;
  logic [CW-1:0] map_out_s;
  logic [CW-1:0] plug_in_s, plug_out_s;

  // A load in the same idle cycle takes priority over an input character.
  assign in_ready  = in_ready_q & ~cfg_load;
  assign accept_s  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign busy      = busy_q;

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_pos
    assign pos[CW*g +: CW] = pos_q[g];
  end

  enigma_rotor_map #(.NUM_ROTORS(NUM_ROTORS)) u_map (
    .char_i  (c_q),
    .pos_i   (pos_q[k_q]),
    .rotor_i (k_q),
    .dir_i   (state_q == S_BWD),
    .char_o  (map_out_s)
  );

`ifdef ENIGMA_PLUGBOARD_EN
  logic [CW-1:0] plug_q [ALPHA];
  logic [CW-1:0] plug_d [ALPHA];

  // Plugboard lookup at capture and at output; non-letters pass through.
  always_comb begin
    if (in_char < 5'(ALPHA)) plug_in_s = plug_q[in_char];
    else                     plug_in_s = in_char;
    if (c_d < 5'(ALPHA))     plug_out_s = plug_q[c_d];
    else                     plug_out_s = c_d;
  end

  // Pair write: old partners of a and b fall back to self before the new pair lands.
  always_comb begin
    plug_d = plug_q;
    if (state_q == S_IDLE && plug_we && plug_a < 5'(ALPHA) && plug_b < 5'(ALPHA)) begin
      plug_d[plug_q[plug_a]] = plug_q[plug_a];
      plug_d[plug_q[plug_b]] = plug_q[plug_b];
      plug_d[plug_a] = plug_b;
      plug_d[plug_b] = plug_a;
    end else begin
      plug_d = plug_q;
    end
  end

  // Plugboard map register, identity after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < ALPHA; j++) plug_q[j] <= 5'(j);
    end else begin
      plug_q <= plug_d;
    end
  end
`else
  // Identity plugboard.
  always_comb begin
    plug_in_s  = in_char;
    plug_out_s = c_d;
  end
`endif

  // FSM next state and character datapath.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          c_d = plug_in_s;
          if (in_char < 5'(ALPHA)) state_d = S_STEP;
          else                     state_d = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        k_d     = 3'd0;
        state_d = S_FWD;
      end
      S_FWD: begin
        c_d = map_out_s;
        if (k_q == LAST) state_d = S_REFL;
        else             k_d = k_q + 3'd1;
      end
      S_REFL: begin
        c_d     = reflect(c_q);
        k_d     = LAST;
        state_d = S_BWD;
      end
      S_BWD: begin
        c_d = map_out_s;
        if (k_q == 3'd0) state_d = S_OUT;
        else             k_d = k_q - 3'd1;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Rotor positions: load in IDLE, odometer step with double-step in STEP.
  always_comb begin
    pos_d = pos_q;
    if (state_q == S_IDLE && cfg_load) begin
      for (int i = 0; i < NUM_ROTORS; i++) begin
        if (cfg_pos[CW*i +: CW] >= 5'(ALPHA)) pos_d[i] = cfg_pos[CW*i +: CW] - 5'(ALPHA);
        else                                  pos_d[i] = cfg_pos[CW*i +: CW];
      end
    end else if (state_q == S_STEP) begin
      for (int i = 0; i < NUM_ROTORS; i++) begin
        if (i == 0 ||
            pos_q[(i == 0) ? 0 : i-1] == notch_of(3'(NUM_ROTORS - i)) ||
            (i < NUM_ROTORS - 1 && pos_q[i] == notch_of(3'(NUM_ROTORS - 1 - i))))
          pos_d[i] = add26(pos_q[i], 5'd1);
        else
          pos_d[i] = pos_q[i];
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      c_q         <= 5'd0;
      for (int i = 0; i < NUM_ROTORS; i++) pos_q[i] <= 5'd0;
      out_char_q  <= 5'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      pos_q       <= pos_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_OUT);
      busy_q      <= (state_d != S_IDLE);
      // Latch the ciphertext once on OUT entry so it stays stable while stalled.
      if (state_d == S_OUT && state_q != S_OUT) out_char_q <= plug_out_s;
      else                                      out_char_q <= out_char_q;
    end
  end

endmodule
